// File: rtl/bp_pkg.sv
// Shared types, encodings and helpers for the branch predict unit.
// Holds the next-PC source enum, branch funct3 codes and the 2-bit counter type.
package bp_pkg;

  typedef enum logic [1:0] {
    PCSRC_SEQ     = 2'b00,
    PCSRC_IMM     = 2'b01,
    PCSRC_ALU     = 2'b10,
    PCSRC_RECOVER = 2'b11
  } pcsrc_t;

  localparam logic [1:0] JUMP_NONE = 2'b00;
  localparam logic [1:0] JUMP_JAL  = 2'b01;
  localparam logic [1:0] JUMP_JALR = 2'b10;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef logic [1:0] bht_ctr_t;
  localparam bht_ctr_t BHT_RESET = 2'b01;

  function automatic bht_ctr_t bht_next(input bht_ctr_t ctr, input logic taken);
    bht_ctr_t nxt;
    nxt = ctr;
    if (taken && ctr != 2'b11) nxt = ctr + 2'b01;
    else if (!taken && ctr != 2'b00) nxt = ctr - 2'b01;
    return nxt;
  endfunction

  // The compare unit reports only zero, so the "equal/ge" forms take on zero
  // and the "ne/lt" forms take on non-zero.
  function automatic logic branch_taken(input logic [2:0] f3, input logic zero);
    logic tk;
    case (f3)
      F3_BEQ, F3_BGE, F3_BGEU: tk = zero;
      F3_BNE, F3_BLT, F3_BLTU: tk = ~zero;
      default:                 tk = 1'b0;
    endcase
    return tk;
  endfunction

endpackage

// File: rtl/bht_array.sv
// Table of 2-bit saturating counters: one combinational read port and one
// synchronous write port that applies the saturating update; async reset to weak-not-taken.
module bht_array
  import bp_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx_i,
  output bht_ctr_t         rd_ctr_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             wr_taken_i
);

  bht_ctr_t ctr_q [ENTRIES];
  bht_ctr_t ctr_d [ENTRIES];

  generate
    if (ENTRIES < 2 || (ENTRIES & (ENTRIES - 1)) != 0) begin : g_bad_entries
      $error("bht_array: ENTRIES must be a power of two and at least 2");
    end
  endgenerate

  // Read sees the registered table only, so a same-cycle write is not bypassed.
  assign rd_ctr_o = ctr_q[rd_idx_i];

  always_comb begin
    ctr_d = ctr_q;
    if (wr_en_i) ctr_d[wr_idx_i] = bht_next(ctr_q[wr_idx_i], wr_taken_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= BHT_RESET;
    end else begin
      ctr_q <= ctr_d;
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Execute-stage jump/branch resolution with a dynamic 2-bit counter predictor read at decode.
// Optional performance counters are built when BRANCH_PERF_EN is defined.
module branch_predict_unit
  import bp_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int IDX_LSB     = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            d_valid_i,
  input  logic            d_branch_i,
  input  logic [XLEN-1:0] d_pc_i,
  output logic            d_pred_taken_o,
  input  logic            e_valid_i,
  input  logic [1:0]      e_jump_i,
  input  logic            e_branch_i,
  input  logic [2:0]      e_branch_type_i,
  input  logic            e_zero_i,
  input  logic            e_pred_taken_i,
  input  logic [XLEN-1:0] e_pc_i,
  output logic [1:0]      e_pcsrc_o,
  output logic            e_flush_o
`ifdef BRANCH_PERF_EN
  ,
  output logic [31:0]     perf_branches_o,
  output logic [31:0]     perf_mispred_o
`endif
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  bht_ctr_t         rd_ctr;
  logic             taken;
  logic             jump_none;
  logic             train;
  pcsrc_t           pcsrc;
  logic             unused_pc_bits;

  assign rd_idx = d_pc_i[IDX_LSB +: IDX_W];
  assign wr_idx = e_pc_i[IDX_LSB +: IDX_W];
  assign unused_pc_bits = ^{d_pc_i, e_pc_i};

  bht_array #(
    .ENTRIES (BHT_ENTRIES),
    .IDX_W   (IDX_W)
  ) u_bht (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_idx_i   (rd_idx),
    .rd_ctr_o   (rd_ctr),
    .wr_en_i    (train),
    .wr_idx_i   (wr_idx),
    .wr_taken_i (taken)
  );

  assign d_pred_taken_o = d_valid_i & d_branch_i & rd_ctr[1];

  assign taken     = branch_taken(e_branch_type_i, e_zero_i);
  assign jump_none = (e_jump_i != JUMP_JAL) && (e_jump_i != JUMP_JALR);
  assign train     = e_valid_i & e_branch_i & jump_none;

  // Jumps win over branches; a correctly predicted branch needs no redirect.
  always_comb begin
    pcsrc = PCSRC_SEQ;
    if (e_valid_i) begin
      if (e_jump_i == JUMP_JAL)             pcsrc = PCSRC_IMM;
      else if (e_jump_i == JUMP_JALR)       pcsrc = PCSRC_ALU;
      else if (e_branch_i) begin
        if (taken && !e_pred_taken_i)       pcsrc = PCSRC_IMM;
        else if (!taken && e_pred_taken_i)  pcsrc = PCSRC_RECOVER;
      end
    end
  end

  assign e_pcsrc_o = pcsrc;
  assign e_flush_o = (pcsrc != PCSRC_SEQ);

`ifdef BRANCH_PERF_EN
  logic [31:0] perf_branches_q, perf_branches_d;
  logic [31:0] perf_mispred_q,  perf_mispred_d;

  // A training cycle redirects only on a misprediction, so any redirect there counts.
  always_comb begin
    perf_branches_d = perf_branches_q;
    perf_mispred_d  = perf_mispred_q;
    if (train) begin
      perf_branches_d = perf_branches_q + 32'd1;
      if (pcsrc == PCSRC_IMM || pcsrc == PCSRC_RECOVER)
        perf_mispred_d = perf_mispred_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_branches_q <= 32'd0;
      perf_mispred_q  <= 32'd0;
    end else begin
      perf_branches_q <= perf_branches_d;
      perf_mispred_q  <= perf_mispred_d;
    end
  end

  assign perf_branches_o = perf_branches_q;
  assign perf_mispred_o  = perf_mispred_q;
`else
  // Without the performance option no counter state exists.
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed self-checking bench for branch_predict_unit (default parameters).
// Perf counter checks are compiled in only when BRANCH_PERF_EN is defined.
module tb_branch_predict_unit;

  logic        clk;
  logic        rst_n;
  logic        d_valid_i;
  logic        d_branch_i;
  logic [31:0] d_pc_i;
  logic        d_pred_taken_o;
  logic        e_valid_i;
  logic [1:0]  e_jump_i;
  logic        e_branch_i;
  logic [2:0]  e_branch_type_i;
  logic        e_zero_i;
  logic        e_pred_taken_i;
  logic [31:0] e_pc_i;
  logic [1:0]  e_pcsrc_o;
  logic        e_flush_o;
`ifdef BRANCH_PERF_EN
  logic [31:0] perf_branches_o;
  logic [31:0] perf_mispred_o;
`endif

  int checks;
  int fails;

  branch_predict_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .d_valid_i       (d_valid_i),
    .d_branch_i      (d_branch_i),
    .d_pc_i          (d_pc_i),
    .d_pred_taken_o  (d_pred_taken_o),
    .e_valid_i       (e_valid_i),
    .e_jump_i        (e_jump_i),
    .e_branch_i      (e_branch_i),
    .e_branch_type_i (e_branch_type_i),
    .e_zero_i        (e_zero_i),
    .e_pred_taken_i  (e_pred_taken_i),
    .e_pc_i          (e_pc_i),
    .e_pcsrc_o       (e_pcsrc_o),
    .e_flush_o       (e_flush_o)
`ifdef BRANCH_PERF_EN
    ,
    .perf_branches_o (perf_branches_o),
    .perf_mispred_o  (perf_mispred_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_exec(input logic v, input logic [1:0] j, input logic b,
                            input logic [2:0] f3, input logic z, input logic p,
                            input logic [31:0] pc);
    e_valid_i       = v;
    e_jump_i        = j;
    e_branch_i      = b;
    e_branch_type_i = f3;
    e_zero_i        = z;
    e_pred_taken_i  = p;
    e_pc_i          = pc;
  endtask

  task automatic drive_decode(input logic [31:0] pc);
    d_valid_i  = 1'b1;
    d_branch_i = 1'b1;
    d_pc_i     = pc;
  endtask

  task automatic test_reset;
    logic [31:0] pcs [3];
    pcs[0] = 32'h0; pcs[1] = 32'h100; pcs[2] = 32'hFFC;
    rst_n = 1'b0;
    drive_exec(1'b0, 2'b01, 1'b1, 3'b000, 1'b1, 1'b0, 32'h0);
    #1;
    checks++;
    if (e_pcsrc_o !== 2'b00 || e_flush_o !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: pcsrc=%b flush=%b expected pcsrc=00 flush=0", e_pcsrc_o, e_flush_o);
    end
    for (int i = 0; i < 3; i++) begin
      drive_decode(pcs[i]);
      #1;
      checks++;
      if (d_pred_taken_o !== 1'b0) begin
        fails++;
        $display("[TB] FAIL reset_pred pc=%h: got %b expected 0", pcs[i], d_pred_taken_o);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_train_taken;
    @(negedge clk);
    drive_decode(32'h40);
    drive_exec(1'b1, 2'b00, 1'b1, 3'b000, 1'b1, 1'b0, 32'h40);
    #1;
    checks++;
    if (e_pcsrc_o !== 2'b01 || e_flush_o !== 1'b1) begin
      fails++;
      $display("[TB] FAIL first_taken_beq: pcsrc=%b flush=%b expected pcsrc=01 flush=1", e_pcsrc_o, e_flush_o);
    end
    checks++;
    if (d_pred_taken_o !== 1'b0) begin
      fails++;
      $display("[TB] FAIL pred_before_train: got %b expected 0", d_pred_taken_o);
    end
    @(negedge clk);
    drive_exec(1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0);
    #1;
    checks++;
    if (d_pred_taken_o !== 1'b1) begin
      fails++;
      $display("[TB] FAIL pred_after_train: got %b expected 1", d_pred_taken_o);
    end
  endtask

  task automatic test_saturate;
    // counter 10 -> 11 -> 11 -> 11, all correctly predicted
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_exec(1'b1, 2'b00, 1'b1, 3'b000, 1'b1, 1'b1, 32'h40);
      #1;
      checks++;
      if (e_pcsrc_o !== 2'b00 || e_flush_o !== 1'b0) begin
        fails++;
        $display("[TB] FAIL correct_taken_%0d: pcsrc=%b flush=%b expected 00/0", i, e_pcsrc_o, e_flush_o);
      end
    end
    @(negedge clk);
    drive_exec(1'b1, 2'b00, 1'b1, 3'b000, 1'b0, 1'b1, 32'h40);
    #1;
    checks++;
    if (e_pcsrc_o !== 2'b11 || e_flush_o !== 1'b1) begin
      fails++;
      $display("[TB] FAIL recover_not_taken: pcsrc=%b flush=%b expected 11/1", e_pcsrc_o, e_flush_o);
    end
    @(negedge clk);
    drive_exec(1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0);
    drive_decode(32'h40);
    #1;
    checks++;
    if (d_pred_taken_o !== 1'b1) begin
      fails++;
      $display("[TB] FAIL pred_after_saturate_dec: got %b expected 1", d_pred_taken_o);
    end
  endtask

  task automatic test_jumps;
    // counter at 0x40 is 10; a trained not-taken BEQ would drop it to 01
    @(negedge clk);
    drive_exec(1'b1, 2'b10, 1'b1, 3'b000, 1'b0, 1'b1, 32'h40);
    #1;
    checks++;
    if (e_pcsrc_o !== 2'b10 || e_flush_o !== 1'b1) begin
      fails++;
      $display("[TB] FAIL jalr: pcsrc=%b flush=%b expected 10/1", e_pcsrc_o, e_flush_o);
    end
    @(negedge clk);
    drive_exec(1'b1, 2'b01, 1'b1, 3'b000, 1'b0, 1'b1, 32'h40);
    #1;
    checks++;
    if (d_pred_taken_o !== 1'b1) begin
      fails++;
      $display("[TB] FAIL jalr_no_train: got %b expected 1", d_pred_taken_o);
    end
    checks++;
    if (e_pcsrc_o !== 2'b01 || e_flush_o !== 1'b1) begin
      fails++;
      $display("[TB] FAIL jal: pcsrc=%b flush=%b expected 01/1", e_pcsrc_o, e_flush_o);
    end
    @(negedge clk);
    drive_exec(1'b0, 2'b01, 1'b1, 3'b000, 1'b0, 1'b1, 32'h40);
    #1;
    checks++;
    if (d_pred_taken_o !== 1'b1) begin
      fails++;
      $display("[TB] FAIL jal_no_train: got %b expected 1", d_pred_taken_o);
    end
    checks++;
    if (e_pcsrc_o !== 2'b00 || e_flush_o !== 1'b0) begin
      fails++;
      $display("[TB] FAIL invalid_jal: pcsrc=%b flush=%b expected 00/0", e_pcsrc_o, e_flush_o);
    end
  endtask

  task automatic test_branch_types;
    // {funct3, zero, expected taken}; predicted not-taken so taken -> 01
    logic [4:0] vec [11];
    vec[0]  = {3'b000, 1'b1, 1'b1};
    vec[1]  = {3'b000, 1'b0, 1'b0};
    vec[2]  = {3'b001, 1'b0, 1'b1};
    vec[3]  = {3'b001, 1'b1, 1'b0};
    vec[4]  = {3'b100, 1'b0, 1'b1};
    vec[5]  = {3'b101, 1'b1, 1'b1};
    vec[6]  = {3'b110, 1'b0, 1'b1};
    vec[7]  = {3'b111, 1'b1, 1'b1};
    vec[8]  = {3'b111, 1'b0, 1'b0};
    vec[9]  = {3'b010, 1'b1, 1'b0};
    vec[10] = {3'b011, 1'b0, 1'b0};
    for (int i = 0; i < 11; i++) begin
      logic [1:0] exp_src;
      @(negedge clk);
      drive_exec(1'b1, 2'b00, 1'b1, vec[i][4:2], vec[i][1], 1'b0, 32'h800);
      exp_src = vec[i][0] ? 2'b01 : 2'b00;
      #1;
      checks++;
      if (e_pcsrc_o !== exp_src || e_flush_o !== vec[i][0]) begin
        fails++;
        $display("[TB] FAIL branch_type f3=%b zero=%b: pcsrc=%b flush=%b expected %b/%b",
                 vec[i][4:2], vec[i][1], e_pcsrc_o, e_flush_o, exp_src, vec[i][0]);
      end
    end
    @(negedge clk);
    drive_exec(1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_alias;
    // 0x140 shares index 16 with 0x40, whose counter is 10
    @(negedge clk);
    drive_decode(32'h140);
    drive_exec(1'b1, 2'b00, 1'b1, 3'b000, 1'b0, 1'b1, 32'h40);
    #1;
    checks++;
    if (d_pred_taken_o !== 1'b1) begin
      fails++;
      $display("[TB] FAIL alias_same_cycle_old: got %b expected 1", d_pred_taken_o);
    end
    @(negedge clk);
    drive_exec(1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0);
    #1;
    checks++;
    if (d_pred_taken_o !== 1'b0) begin
      fails++;
      $display("[TB] FAIL alias_next_cycle_new: got %b expected 0", d_pred_taken_o);
    end
  endtask

  task automatic test_reset_mid_train;
    // raise index 16 from 01 to 11, then reset during a further training cycle
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive_exec(1'b1, 2'b00, 1'b1, 3'b000, 1'b1, 1'b0, 32'h40);
    end
    @(negedge clk);
    drive_exec(1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0);
    drive_decode(32'h40);
    #1;
    checks++;
    if (d_pred_taken_o !== 1'b1) begin
      fails++;
      $display("[TB] FAIL pred_before_reset: got %b expected 1", d_pred_taken_o);
    end
    drive_exec(1'b1, 2'b00, 1'b1, 3'b000, 1'b1, 1'b1, 32'h40);
    rst_n = 1'b0;
    @(negedge clk);
    drive_exec(1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b1;
    #1;
    checks++;
    if (d_pred_taken_o !== 1'b0) begin
      fails++;
      $display("[TB] FAIL pred_after_mid_reset: got %b expected 0", d_pred_taken_o);
    end
    @(negedge clk);
    drive_exec(1'b1, 2'b00, 1'b1, 3'b000, 1'b1, 1'b0, 32'h140);
    @(negedge clk);
    drive_exec(1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0);
    #1;
    checks++;
    if (d_pred_taken_o !== 1'b1) begin
      fails++;
      $display("[TB] FAIL one_step_from_reset: got %b expected 1", d_pred_taken_o);
    end
  endtask

`ifdef BRANCH_PERF_EN
  task automatic test_perf;
    // {zero, predicted}: BEQ mispredicts when these differ
    logic [1:0] pat [5];
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pat[0] = 2'b11; pat[1] = 2'b10; pat[2] = 2'b00; pat[3] = 2'b01; pat[4] = 2'b11;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive_exec(1'b1, 2'b00, 1'b1, 3'b000, pat[i][1], pat[i][0], 32'h200);
    end
    @(negedge clk);
    drive_exec(1'b1, 2'b10, 1'b1, 3'b000, 1'b0, 1'b1, 32'h200);
    @(negedge clk);
    drive_exec(1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0);
    #1;
    checks++;
    if (perf_branches_o !== 32'd5 || perf_mispred_o !== 32'd2) begin
      fails++;
      $display("[TB] FAIL perf_counts: branches=%0d mispred=%0d expected 5/2", perf_branches_o, perf_mispred_o);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (perf_branches_o !== 32'd0 || perf_mispred_o !== 32'd0) begin
      fails++;
      $display("[TB] FAIL perf_reset: branches=%0d mispred=%0d expected 0/0", perf_branches_o, perf_mispred_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    checks = 0;
    fails  = 0;
    d_valid_i  = 1'b0;
    d_branch_i = 1'b0;
    d_pc_i     = 32'h0;
    test_reset();
    test_train_taken();
    test_saturate();
    test_jumps();
    test_branch_types();
    test_alias();
    test_reset_mid_train();
`ifdef BRANCH_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
